// File: rtl/nabp_shift_accumulator.sv
// Walks LINES line positions per projection angle, accumulating |tan/cot| into a fractional
// accumulator and issuing a one-line shift command on every fractional carry.
module nabp_shift_accumulator #(
    parameter int ANGLE_W = 9,
    parameter int FRAC_W  = 10,
    parameter int BASE_W  = 12,
    parameter int LINES   = 256,
    parameter int LINE_W  = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sh_kick,
    input  logic [ANGLE_W-1:0]  sh_angle,
    output logic                sh_ready,
    output logic                sh_err,
    output logic [ANGLE_W-1:0]  lut_angle,
    input  logic [BASE_W-1:0]   lut_accu_base,
    input  logic                sh_stall,
    output logic                sh_line_valid,
    output logic [LINE_W-1:0]   sh_line_idx,
    output logic                sh_shift_en,
    output logic                sh_shift_dir,
    output logic                sh_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LUT_REQ,
        S_LUT_CAP,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [ANGLE_W-1:0] ANGLE_MAX = ANGLE_W'(179);
    localparam logic [FRAC_W:0]    ONE       = {1'b1, {FRAC_W{1'b0}}};
    localparam logic [FRAC_W-1:0]  HALF      = {1'b1, {(FRAC_W-1){1'b0}}};
    localparam logic [LINE_W-1:0]  LAST_LINE = LINE_W'(LINES - 1);

    state_t              state_q, state_d;
    logic [ANGLE_W-1:0]  lut_angle_q, lut_angle_d;
    logic                dir_q, dir_d;
    logic [FRAC_W:0]     mag_q, mag_d;
    logic [FRAC_W-1:0]   acc_q, acc_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                ready_q, ready_d;
    logic                err_q, err_d;
    logic                vld_q, vld_d;
    logic [LINE_W-1:0]   idx_q, idx_d;
    logic                shift_q, shift_d;
    logic                sdir_q, sdir_d;
    logic                done_q, done_d;

    logic [BASE_W-1:0]   base_abs;
    logic [FRAC_W:0]     mag_clamped;
    logic [FRAC_W:0]     sum;

    // Negating the most-negative code yields itself, which as unsigned exceeds 1.0 and clamps.
    always_comb begin
        base_abs    = lut_accu_base[BASE_W-1] ? (BASE_W'(0) - lut_accu_base) : lut_accu_base;
        mag_clamped = (base_abs > BASE_W'(ONE)) ? ONE : base_abs[FRAC_W:0];
        sum         = {1'b0, acc_q} + mag_q;
    end

    always_comb begin
        state_d     = state_q;
        lut_angle_d = lut_angle_q;
        dir_d       = dir_q;
        mag_d       = mag_q;
        acc_d       = acc_q;
        line_d      = line_q;
        ready_d     = ready_q;
        err_d       = 1'b0;
        vld_d       = vld_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        sdir_d      = sdir_q;
        done_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (sh_kick) begin
                    if (sh_angle > ANGLE_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        lut_angle_d = sh_angle;
                        ready_d     = 1'b0;
                        state_d     = S_LUT_REQ;
                    end
                end
            end
            S_LUT_REQ: state_d = S_LUT_CAP;
            S_LUT_CAP: begin
                dir_d   = lut_accu_base[BASE_W-1];
                mag_d   = mag_clamped;
                acc_d   = HALF;
                line_d  = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!sh_stall) begin
                    // The beat on the output is accepted at this edge; the last one ends the pass.
                    if (vld_q && idx_q == LAST_LINE) begin
                        vld_d   = 1'b0;
                        idx_d   = '0;
                        shift_d = 1'b0;
                        sdir_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        vld_d   = 1'b1;
                        idx_d   = line_q;
                        shift_d = sum[FRAC_W];
                        sdir_d  = dir_q;
                        acc_d   = sum[FRAC_W-1:0];
                        if (line_q != LAST_LINE) begin
                            line_d = line_q + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                ready_d = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            lut_angle_q <= '0;
            dir_q       <= 1'b0;
            mag_q       <= '0;
            acc_q       <= '0;
            line_q      <= '0;
            ready_q     <= 1'b1;
            err_q       <= 1'b0;
            vld_q       <= 1'b0;
            idx_q       <= '0;
            shift_q     <= 1'b0;
            sdir_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            lut_angle_q <= lut_angle_d;
            dir_q       <= dir_d;
            mag_q       <= mag_d;
            acc_q       <= acc_d;
            line_q      <= line_d;
            ready_q     <= ready_d;
            err_q       <= err_d;
            vld_q       <= vld_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            sdir_q      <= sdir_d;
            done_q      <= done_d;
        end
    end

    assign sh_ready      = ready_q;
    assign sh_err        = err_q;
    assign lut_angle     = lut_angle_q;
    assign sh_line_valid = vld_q;
    assign sh_line_idx   = idx_q;
    assign sh_shift_en   = shift_q;
    assign sh_shift_dir  = sdir_q;
    assign sh_done       = done_q;

endmodule

// File: tb/tb_nabp_shift_accumulator.sv
// Bench for nabp_shift_accumulator: registered LUT model, per-beat model compare, directed passes.
module tb_nabp_shift_accumulator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sh_kick = 1'b0;
    logic [8:0]  sh_angle = '0;
    logic        sh_ready;
    logic        sh_err;
    logic [8:0]  lut_angle;
    logic [11:0] lut_accu_base = '0;
    logic        sh_stall = 1'b0;
    logic        sh_line_valid;
    logic [7:0]  sh_line_idx;
    logic        sh_shift_en;
    logic        sh_shift_dir;
    logic        sh_done;

    int n_cmp = 0;
    int n_bad = 0;
    int base_tab [512];
    int cur_base = 0;
    int exp_idx = 0;
    int shifts = 0;
    bit chk_en = 1'b0;

    nabp_shift_accumulator dut (
        .clk(clk), .reset(reset), .sh_kick(sh_kick), .sh_angle(sh_angle),
        .sh_ready(sh_ready), .sh_err(sh_err), .lut_angle(lut_angle),
        .lut_accu_base(lut_accu_base), .sh_stall(sh_stall),
        .sh_line_valid(sh_line_valid), .sh_line_idx(sh_line_idx),
        .sh_shift_en(sh_shift_en), .sh_shift_dir(sh_shift_dir), .sh_done(sh_done)
    );

    always #5 clk = ~clk;

    // LUT: result registered one cycle after the angle.
    always @(posedge clk) lut_accu_base <= 12'(base_tab[lut_angle]);

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Line i shifts iff the rounded running position (i*|b| + 0.5) crosses an integer.
    function automatic int model_shift(input int base, input int i);
        int mag;
        mag = (base < 0) ? -base : base;
        if (mag > 1024) mag = 1024;
        return (((i + 1) * mag + 512) / 1024 != (i * mag + 512) / 1024) ? 1 : 0;
    endfunction

    always @(negedge clk) begin
        if (chk_en && sh_line_valid) begin
            chk("idx", int'(sh_line_idx), exp_idx);
            chk("shift_en", int'(sh_shift_en), model_shift(cur_base, exp_idx));
            chk("shift_dir", int'(sh_shift_dir), (cur_base < 0) ? 1 : 0);
            if (!sh_stall) begin
                shifts += int'(sh_shift_en);
                exp_idx++;
            end
        end
    end

    task automatic run_pass(input int ang, input int exp_shifts, input bit do_stall,
                            input bit kick_mid, input int abort_at);
        int  stall_left;
        bit  stalled_done;
        bit  prev_last;
        bit  finished;
        cur_base = base_tab[ang];
        exp_idx = 0; shifts = 0; stall_left = 0; stalled_done = 0; prev_last = 0; finished = 0;
        @(posedge clk); #1;
        chk("ready_before_kick", int'(sh_ready), 1);
        sh_kick = 1'b1; sh_angle = 9'(ang);
        @(posedge clk); #1;
        sh_kick = 1'b0;
        chk("ready_after_kick", int'(sh_ready), 0);
        chk("lut_angle", int'(lut_angle), ang);
        chk_en = 1'b1;
        @(posedge clk); #1; chk("vld_k1", int'(sh_line_valid), 0);
        @(posedge clk); #1; chk("vld_k2", int'(sh_line_valid), 0);
        @(posedge clk); #1; chk("vld_k3", int'(sh_line_valid), 1);
        chk("idx_k3", int'(sh_line_idx), 0);
        for (int cyc = 0; cyc < 2000 && !finished; cyc++) begin
            chk("no_err_in_pass", int'(sh_err), 0);
            if (abort_at >= 0 && sh_line_valid && int'(sh_line_idx) == abort_at) begin
                chk_en = 1'b0;
                #2 reset = 1'b1;
                #1;
                chk("abort_vld", int'(sh_line_valid), 0);
                chk("abort_ready", int'(sh_ready), 1);
                chk("abort_lut_angle", int'(lut_angle), 0);
                chk("abort_shift_en", int'(sh_shift_en), 0);
                chk("abort_idx", int'(sh_line_idx), 0);
                chk("abort_done", int'(sh_done), 0);
                @(negedge clk); reset = 1'b0;
                repeat (5) begin
                    @(posedge clk); #1;
                    chk("no_done_after_abort", int'(sh_done), 0);
                    chk("ready_after_abort", int'(sh_ready), 1);
                    chk("no_vld_after_abort", int'(sh_line_valid), 0);
                end
                finished = 1'b1;
            end else if (sh_done) begin
                chk("done_after_last", int'(prev_last), 1);
                chk("vld_at_done", int'(sh_line_valid), 0);
                chk("ready_at_done", int'(sh_ready), 0);
                chk("beats", exp_idx, 256);
                chk("shifts", shifts, exp_shifts);
                @(posedge clk); #1;
                chk("ready_after_done", int'(sh_ready), 1);
                chk("done_one_cycle", int'(sh_done), 0);
                finished = 1'b1;
            end else begin
                sh_kick = 1'b0;
                if (stall_left > 0) begin
                    stall_left--;
                    if (stall_left == 0) sh_stall = 1'b0;
                end else if (do_stall && !stalled_done && sh_line_valid && sh_line_idx == 8'd10) begin
                    sh_stall = 1'b1; stall_left = 3; stalled_done = 1'b1;
                end
                if (kick_mid && sh_line_valid && sh_line_idx == 8'd50) begin
                    sh_kick = 1'b1; sh_angle = 9'd200;
                end
                prev_last = sh_line_valid && sh_line_idx == 8'd255 && !sh_stall;
                @(posedge clk); #1;
            end
        end
        sh_kick = 1'b0;
        sh_stall = 1'b0;
        if (!finished) chk("pass_timeout", 0, 1);
        chk_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) base_tab[i] = 0;
        base_tab[10]  = 512;     // +0.5
        base_tab[20]  = -256;    // -0.25
        base_tab[30]  = 0;
        base_tab[40]  = 1024;    // 1.0
        base_tab[50]  = 2047;    // clamps to 1.0
        base_tab[0]   = -2048;   // most negative, maps to 1.0
        base_tab[179] = 300;     // 256*300/1024 + 0.5 -> 75 carries

        chk("model_pin_l0", model_shift(-256, 0), 0);
        chk("model_pin_l1", model_shift(-256, 1), 1);

        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_ready", int'(sh_ready), 1);
        chk("rst_vld", int'(sh_line_valid), 0);
        chk("rst_lut_angle", int'(lut_angle), 0);
        chk("rst_err", int'(sh_err), 0);
        chk("rst_done", int'(sh_done), 0);
        chk("rst_shift_en", int'(sh_shift_en), 0);

        sh_kick = 1'b1; sh_angle = 9'd180;
        @(posedge clk); #1;
        sh_kick = 1'b0;
        chk("err_180", int'(sh_err), 1);
        chk("ready_180", int'(sh_ready), 1);
        chk("lut_angle_180", int'(lut_angle), 0);
        @(posedge clk); #1;
        chk("err_one_cycle", int'(sh_err), 0);
        chk("ready_after_err", int'(sh_ready), 1);
        sh_kick = 1'b1; sh_angle = 9'd511;
        @(posedge clk); #1;
        sh_kick = 1'b0;
        chk("err_511", int'(sh_err), 1);
        chk("lut_angle_511", int'(lut_angle), 0);

        run_pass(10,  128, 1'b0, 1'b1, -1);
        run_pass(20,   64, 1'b0, 1'b0, -1);
        run_pass(30,    0, 1'b0, 1'b0, -1);
        run_pass(40,  256, 1'b0, 1'b0, -1);
        run_pass(50,  256, 1'b0, 1'b0, -1);
        run_pass(0,   256, 1'b0, 1'b0, -1);
        run_pass(179,  75, 1'b0, 1'b0, -1);
        run_pass(10,  128, 1'b1, 1'b0, -1);
        run_pass(20,   64, 1'b0, 1'b0, 100);
        run_pass(179,  75, 1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
